// File: rtl/param_fifo_pkg.sv
// Shared helpers for the parametrised stream FIFO: usedw width derivation
// and the elaboration-time parameter legality check.
package param_fifo_pkg;

    // usedw must count 0..NUMWORDS+1 (RAM plus output register)
    function automatic int usedw_width(input int numwords);
        return $clog2(numwords + 2);
    endfunction

    function automatic bit params_ok(input int width_data,
                                     input int numwords,
                                     input int afull_lvl,
                                     input int aempty_lvl);
        return (width_data >= 1) && (numwords >= 2) &&
               (afull_lvl >= 1) && (afull_lvl <= numwords + 1) &&
               (aempty_lvl >= 0) && (aempty_lvl <= numwords);
    endfunction

endpackage

// File: rtl/param_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
module param_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_stream_fifo.sv
// Single-clock FIFO: write-enable producer, valid/ready show-ahead consumer
// with a registered head word, empty bypass, level flags, flush and sticky overflow.
module param_stream_fifo
    import param_fifo_pkg::*;
#(
    parameter int WIDTH_DATA = 8,
    parameter int NUMWORDS   = 16,
    parameter int AFULL_LVL  = NUMWORDS,
    parameter int AEMPTY_LVL = 1,
    parameter int _WIDTH_UW  = usedw_width(NUMWORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH_DATA-1:0] wr_data,
    output logic                  full,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH_DATA-1:0] m_data,
    output logic [_WIDTH_UW-1:0]  usedw,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  ovf,
    input  logic                  clr_err
);

    localparam int UW  = _WIDTH_UW;
    localparam int AW  = $clog2(NUMWORDS);
    localparam int CAP = NUMWORDS + 1;

    if (!params_ok(WIDTH_DATA, NUMWORDS, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
        $error("param_stream_fifo: illegal parameter combination");
    end

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [UW-1:0]         ram_cnt;
    logic [WIDTH_DATA-1:0] ram_q;
    logic                  ram_nonempty;
    logic                  wr_acc;
    logic                  pop;
    logic                  load;
    logic                  bypass;
    logic                  ram_wr;
    logic                  ram_rd;

    // The output register is occupied whenever m_valid is set, so the RAM
    // holds whatever usedw counts beyond it.
    assign ram_cnt      = usedw - UW'(m_valid);
    assign ram_nonempty = (ram_cnt != '0);

    assign full         = (usedw == UW'(CAP));
    assign almost_full  = (usedw >= UW'(AFULL_LVL));
    assign almost_empty = (usedw <= UW'(AEMPTY_LVL));

    assign wr_acc = wr_en && !full && !flush;
    assign pop    = m_valid && m_ready && !flush;
    assign load   = (!m_valid || pop) && !flush;
    assign ram_rd = load && ram_nonempty;
    assign bypass = load && !ram_nonempty && wr_acc;
    assign ram_wr = wr_acc && !bypass;

    param_ram #(
        .WIDTH (WIDTH_DATA),
        .DEPTH (NUMWORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_wr),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            usedw   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            usedw   <= '0;
            m_valid <= 1'b0;
        end else begin
            if (ram_wr) begin
                wr_ptr <= (wr_ptr == AW'(NUMWORDS - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (ram_rd) begin
                rd_ptr <= (rd_ptr == AW'(NUMWORDS - 1)) ? '0 : rd_ptr + AW'(1);
            end
            // RAM head takes precedence over bypass so older words leave first
            if (load) begin
                m_valid <= ram_nonempty || wr_acc;
                if (ram_nonempty) begin
                    m_data <= ram_q;
                end else if (wr_acc) begin
                    m_data <= wr_data;
                end
            end
            case ({wr_acc, pop})
                2'b10:   usedw <= usedw + UW'(1);
                2'b01:   usedw <= usedw - UW'(1);
                default: usedw <= usedw;
            endcase
        end
    end

    // A dropped write outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (wr_en && full && !flush) begin
            ovf <= 1'b1;
        end else if (clr_err) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_stream_fifo.sv
// Directed and randomised checks of param_stream_fifo (depth 4, capacity 5)
// against hand-computed values and a small queue model.
module tb_param_stream_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [2:0] usedw;
    logic       almost_full;
    logic       almost_empty;
    logic       ovf;
    logic       clr_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_q[$];
    logic       model_ovf;

    param_stream_fifo #(
        .WIDTH_DATA (8),
        .NUMWORDS   (4),
        .AFULL_LVL  (4),
        .AEMPTY_LVL (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .usedw        (usedw),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf          (ovf),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs, then settle just after the next rising edge
    task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic rdy,
                                 input logic fl, input logic ce);
        wr_en   = we;
        wr_data = wd;
        m_ready = rdy;
        flush   = fl;
        clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        m_ready = 1'b0;
        clr_err = 1'b0;
        $display("[TB] reset with wr_en held high");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_usedw", 32'(usedw), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'h00);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_almost_empty", 32'(almost_empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("post_rst_usedw", 32'(usedw), 32'd0);

        $display("[TB] bypass write into empty FIFO");
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        checkOutput("bypass_m_valid", 32'(m_valid), 32'd1);
        checkOutput("bypass_m_data", 32'(m_data), 32'hA5);
        checkOutput("bypass_usedw", 32'(usedw), 32'd1);
        checkOutput("bypass_almost_empty", 32'(almost_empty), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_m_data", 32'(m_data), 32'hA5);
        checkOutput("hold_m_valid", 32'(m_valid), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("pop_m_valid", 32'(m_valid), 32'd0);
        checkOutput("pop_usedw", 32'(usedw), 32'd0);

        $display("[TB] fill to full and overflow");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("fill%0d_usedw", i), 32'(usedw), (i > 5) ? 32'd5 : 32'(i));
            checkOutput($sformatf("fill%0d_full", i), 32'(full), (i >= 5) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fill%0d_afull", i), 32'(almost_full), (i >= 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fill%0d_ovf", i), 32'(ovf), (i == 6) ? 32'd1 : 32'd0);
        end
        for (int k = 1; k <= 5; k++) begin
            checkOutput($sformatf("drain%0d_valid", k), 32'(m_valid), 32'd1);
            checkOutput($sformatf("drain%0d_data", k), 32'(m_data), 32'(k));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("drained_m_valid", 32'(m_valid), 32'd0);
        checkOutput("drained_usedw", 32'(usedw), 32'd0);
        checkOutput("drained_ovf_sticky", 32'(ovf), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_err_ovf", 32'(ovf), 32'd0);

        $display("[TB] streaming with simultaneous write and pop");
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("stream%0d_data", i), 32'(m_data), 32'(8'h10 + i));
            checkOutput($sformatf("stream%0d_usedw", i), 32'(usedw), 32'd2);
            applyStimulus(1'b1, 8'(8'h12 + i), 1'b1, 1'b0, 1'b0);
        end
        checkOutput("stream_end_data", 32'(m_data), 32'h24);
        checkOutput("stream_end_usedw", 32'(usedw), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("stream_tail_data", 32'(m_data), 32'h25);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("stream_empty_valid", 32'(m_valid), 32'd0);

        $display("[TB] flush with pending write and pop");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("preflush_ovf", 32'(ovf), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("preflush_usedw", 32'(usedw), 32'd3);
        checkOutput("preflush_data", 32'(m_data), 32'h32);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_usedw", 32'(usedw), 32'd0);
        checkOutput("flush_m_valid", 32'(m_valid), 32'd0);
        checkOutput("flush_ovf", 32'(ovf), 32'd1);
        checkOutput("flush_m_data_held", 32'(m_data), 32'h32);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("postflush_m_valid", 32'(m_valid), 32'd0);
        applyStimulus(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        checkOutput("postflush_head0", 32'(m_data), 32'h40);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("postflush_head1", 32'(m_data), 32'h41);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("postflush_empty", 32'(m_valid), 32'd0);
        checkOutput("postflush_clr", 32'(ovf), 32'd0);

        $display("[TB] random traffic against queue model");
        model_q.delete();
        model_ovf = 1'b0;
        for (int c = 0; c < 300; c++) begin
            logic       we;
            logic       rdy;
            logic [7:0] wd;
            logic       m_full;
            we  = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            wd  = 8'($urandom);
            checkOutput("rnd_usedw", 32'(usedw), 32'(model_q.size()));
            checkOutput("rnd_valid", 32'(m_valid), (model_q.size() > 0) ? 32'd1 : 32'd0);
            if (model_q.size() > 0) begin
                checkOutput("rnd_data", 32'(m_data), 32'(model_q[0]));
            end
            m_full = (model_q.size() == 5);
            checkOutput("rnd_full", 32'(full), 32'(m_full));
            checkOutput("rnd_afull", 32'(almost_full), (model_q.size() >= 4) ? 32'd1 : 32'd0);
            checkOutput("rnd_aempty", 32'(almost_empty), (model_q.size() <= 1) ? 32'd1 : 32'd0);
            checkOutput("rnd_ovf", 32'(ovf), 32'(model_ovf));
            if (rdy && model_q.size() > 0) begin
                void'(model_q.pop_front());
            end
            if (we && !m_full) begin
                model_q.push_back(wd);
            end
            if (we && m_full) begin
                model_ovf = 1'b1;
            end
            applyStimulus(we, wd, rdy, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
